// File: rtl/jt49_pkg.sv
// Shared definitions for the JT49 PSG register-port arbiter: FSM encoding,
// requester ids and PSG register constants.
package jt49_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_GAP     = 2'd3
  } state_t;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  // Writing this register restarts the envelope generator
  localparam logic [3:0] ENV_SHAPE = 4'hD;

endpackage

// File: rtl/jt49_rr_arb2.sv
// Two-way arbiter: round-robin or fixed priority (A first), with a last-grant
// pointer that only moves when a grant is actually taken.
module jt49_rr_arb2
  import jt49_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [1:0] i_req,   // bit 0 = A, bit 1 = B
  output logic [1:0] o_gnt
);

  logic r_last;
  logic w_pick_b;

  // B wins when alone, or on a tie when round-robin and A was served last
  assign w_pick_b = i_req[1] & (~i_req[0] | ((FIXED_PRIO == 0) & (r_last == OWN_A)));
  assign o_gnt    = i_en ? {w_pick_b, i_req[0] & ~w_pick_b} : 2'b00;

  always_ff @(posedge clk) begin
    if (rst)
      r_last <= OWN_B;
    else if (|o_gnt)
      r_last <= o_gnt[1];
  end

endmodule

// File: rtl/jt49_bus_arb.sv
// Shares the single JT49 register port between two requesters. Each accepted
// access gives one chip-select cycle, a capture cycle and an optional idle gap.
module jt49_bus_arb
  import jt49_pkg::*;
#(
  parameter int GAP        = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic [3:0] a_addr,
  input  logic [7:0] a_din,
  input  logic       a_wr,
  output logic       a_rvalid,
  output logic [7:0] a_rdata,
  input  logic       b_valid,
  output logic       b_ready,
  input  logic [3:0] b_addr,
  input  logic [7:0] b_din,
  input  logic       b_wr,
  output logic       b_rvalid,
  output logic [7:0] b_rdata,
  output logic       psg_cs_n,
  output logic       psg_wr_n,
  output logic [3:0] psg_addr,
  output logic [7:0] psg_din,
  input  logic [7:0] psg_dout,
  output logic       busy
);

  localparam logic [3:0] GAP_LD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t     r_state;
  logic       r_own;
  logic       r_wr;
  logic [3:0] r_cnt;
  logic       r_cs_n;
  logic       r_wr_n;
  logic [3:0] r_addr;
  logic [7:0] r_din;
  logic       r_a_rvalid;
  logic       r_b_rvalid;
  logic [7:0] r_a_rdata;
  logic [7:0] r_b_rdata;

  logic [1:0] w_gnt;
  logic       w_en;
  logic       w_wr;
  logic [3:0] w_addr;
  logic [7:0] w_din;

  assign w_en = ~rst & (r_state == ST_IDLE);

  jt49_rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_en),
    .i_req ({b_valid, a_valid}),
    .o_gnt (w_gnt)
  );

  assign a_ready = w_gnt[0];
  assign b_ready = w_gnt[1];
  assign w_wr    = w_gnt[1] ? b_wr   : a_wr;
  assign w_addr  = w_gnt[1] ? b_addr : a_addr;
  assign w_din   = w_gnt[1] ? b_din  : a_din;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_own      <= OWN_A;
      r_wr       <= 1'b0;
      r_cnt      <= 4'd0;
      r_cs_n     <= 1'b1;
      r_wr_n     <= 1'b1;
      r_addr     <= 4'd0;
      r_din      <= 8'd0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= 8'd0;
      r_b_rdata  <= 8'd0;
    end else begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_cs_n     <= 1'b1;
      r_wr_n     <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (|w_gnt) begin
            r_state <= ST_ACCESS;
            r_own   <= w_gnt[1];
            r_wr    <= w_wr;
            r_addr  <= w_addr;
            r_din   <= w_din;
            r_cs_n  <= 1'b0;
            r_wr_n  <= ~w_wr;
          end
        end
        ST_ACCESS: r_state <= ST_CAPTURE;
        ST_CAPTURE: begin
          // PSG read data is valid the cycle after chip select
          if (!r_wr) begin
            if (r_own == OWN_B) begin
              r_b_rdata  <= psg_dout;
              r_b_rvalid <= 1'b1;
            end else begin
              r_a_rdata  <= psg_dout;
              r_a_rvalid <= 1'b1;
            end
          end
          if (GAP > 0) begin
            r_state <= ST_GAP;
            r_cnt   <= GAP_LD;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_GAP: begin
          if (r_cnt == 4'd0) r_state <= ST_IDLE;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign psg_cs_n = r_cs_n;
  assign psg_wr_n = r_wr_n;
  assign psg_addr = r_addr;
  assign psg_din  = r_din;
  assign a_rvalid = r_a_rvalid;
  assign b_rvalid = r_b_rvalid;
  assign a_rdata  = r_a_rdata;
  assign b_rdata  = r_b_rdata;
  assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_jt49_bus_arb.sv
// Bench for jt49_bus_arb: three instances (GAP=1 RR, GAP=1 fixed, GAP=0 RR),
// a transaction-timeline model checked every cycle, plus directed scenarios.
module tb_jt49_bus_arb;
  import jt49_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] a_valid = '0, a_wr = '0, b_valid = '0, b_wr = '0;
  logic [3:0] a_addr [3];
  logic [3:0] b_addr [3];
  logic [7:0] a_din  [3];
  logic [7:0] b_din  [3];
  logic [7:0] psg_dout [3];
  wire  [2:0] a_ready, b_ready, a_rvalid, b_rvalid, psg_cs_n, psg_wr_n, busy;
  wire  [7:0] a_rdata [3];
  wire  [7:0] b_rdata [3];
  wire  [3:0] psg_addr [3];
  wire  [7:0] psg_din [3];

  for (genvar k = 0; k < 3; k++) begin : g_dut
    jt49_bus_arb #(.GAP(k == 2 ? 0 : 1), .FIXED_PRIO(k == 1 ? 1 : 0)) u_dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid[k]), .a_ready(a_ready[k]), .a_addr(a_addr[k]), .a_din(a_din[k]),
      .a_wr(a_wr[k]), .a_rvalid(a_rvalid[k]), .a_rdata(a_rdata[k]),
      .b_valid(b_valid[k]), .b_ready(b_ready[k]), .b_addr(b_addr[k]), .b_din(b_din[k]),
      .b_wr(b_wr[k]), .b_rvalid(b_rvalid[k]), .b_rdata(b_rdata[k]),
      .psg_cs_n(psg_cs_n[k]), .psg_wr_n(psg_wr_n[k]), .psg_addr(psg_addr[k]),
      .psg_din(psg_din[k]), .psg_dout(psg_dout[k]), .busy(busy[k])
    );
  end

  int n_cmp = 0, n_bad = 0, cyc = 0;

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // PSG register file: registered read data, counts envelope-shape writes
  logic [7:0] mem [3][16];
  int env_cnt [3];
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        for (int i = 0; i < 16; i++) mem[k][i] <= (i == 2) ? 8'h5A : 8'h00;
        psg_dout[k] <= 8'h00;
        env_cnt[k]  <= 0;
      end else if (!psg_cs_n[k]) begin
        if (!psg_wr_n[k]) begin
          mem[k][psg_addr[k]] <= psg_din[k];
          if (psg_addr[k] == ENV_SHAPE) env_cnt[k] <= env_cnt[k] + 1;
        end
        psg_dout[k] <= mem[k][psg_addr[k]];
      end
    end
  end

  // Model: each access is a timeline measured in cycles since acceptance.
  // age 0 = chip-select cycle, 1 = read data available, busy until 2+gap.
  int         m_age  [3];
  logic       m_lastb[3], m_ownb[3], m_wr[3], m_arv[3], m_brv[3];
  logic [3:0] m_addr [3];
  logic [7:0] m_din  [3], m_ard[3], m_brd[3];

  function automatic int gap_of(int k);
    return (k == 2) ? 0 : 1;
  endfunction

  function automatic logic [1:0] pick(logic av, logic bv, logic last_b, bit fixed);
    if (av && bv) return (fixed || last_b) ? 2'b01 : 2'b10;
    return {bv, av};
  endfunction

  always @(posedge clk) begin
    logic [1:0] g;
    cyc++;
    for (int k = 0; k < 3; k++) begin
      m_arv[k] = 1'b0;
      m_brv[k] = 1'b0;
      if (rst) begin
        m_age[k] = -1; m_lastb[k] = 1'b1; m_addr[k] = 4'd0; m_din[k] = 8'd0;
        m_ard[k] = 8'd0; m_brd[k] = 8'd0; m_wr[k] = 1'b0; m_ownb[k] = 1'b0;
      end else if (m_age[k] < 0) begin
        g = pick(a_valid[k], b_valid[k], m_lastb[k], k == 1);
        if (g != 2'b00) begin
          m_ownb[k] = g[1]; m_lastb[k] = g[1];
          m_wr[k]   = g[1] ? b_wr[k]   : a_wr[k];
          m_addr[k] = g[1] ? b_addr[k] : a_addr[k];
          m_din[k]  = g[1] ? b_din[k]  : a_din[k];
          m_age[k]  = 0;
        end
      end else begin
        if (m_age[k] == 1 && !m_wr[k]) begin
          if (m_ownb[k]) begin m_brd[k] = psg_dout[k]; m_brv[k] = 1'b1; end
          else           begin m_ard[k] = psg_dout[k]; m_arv[k] = 1'b1; end
        end
        m_age[k]++;
        if (m_age[k] >= 2 + gap_of(k)) m_age[k] = -1;
      end
    end
  end

  // Per-cycle compare plus activity counters for the directed checks
  int cs_cnt[3], wrn_cnt[3], busy_cnt[3], arv_cnt[3], brv_cnt[3];
  int brv_cyc[3], brv_dat[3], cs_addr[3], cs_din[3];
  always @(negedge clk) begin
    logic [1:0] g;
    if (cyc > 0) begin
      for (int k = 0; k < 3; k++) begin
        g = (!rst && m_age[k] < 0) ? pick(a_valid[k], b_valid[k], m_lastb[k], k == 1) : 2'b00;
        chk($sformatf("i%0d_a_ready", k), int'(a_ready[k]), int'(g[0]));
        chk($sformatf("i%0d_b_ready", k), int'(b_ready[k]), int'(g[1]));
        chk($sformatf("i%0d_cs_n", k), int'(psg_cs_n[k]), int'(m_age[k] != 0));
        chk($sformatf("i%0d_wr_n", k), int'(psg_wr_n[k]), int'(m_age[k] != 0 || !m_wr[k]));
        chk($sformatf("i%0d_addr", k), int'(psg_addr[k]), int'(m_addr[k]));
        chk($sformatf("i%0d_din", k), int'(psg_din[k]), int'(m_din[k]));
        chk($sformatf("i%0d_busy", k), int'(busy[k]), int'(m_age[k] >= 0));
        chk($sformatf("i%0d_a_rvalid", k), int'(a_rvalid[k]), int'(m_arv[k]));
        chk($sformatf("i%0d_b_rvalid", k), int'(b_rvalid[k]), int'(m_brv[k]));
        chk($sformatf("i%0d_a_rdata", k), int'(a_rdata[k]), int'(m_ard[k]));
        chk($sformatf("i%0d_b_rdata", k), int'(b_rdata[k]), int'(m_brd[k]));
        if (!psg_cs_n[k]) begin
          cs_cnt[k]++; cs_addr[k] = int'(psg_addr[k]); cs_din[k] = int'(psg_din[k]);
          if (!psg_wr_n[k]) wrn_cnt[k]++;
        end
        if (busy[k]) busy_cnt[k]++;
        if (a_rvalid[k]) arv_cnt[k]++;
        if (b_rvalid[k]) begin brv_cnt[k]++; brv_cyc[k] = cyc; brv_dat[k] = int'(b_rdata[k]); end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic send(int k, bit who_b, logic [3:0] ad, logic [7:0] d, bit wr, output int tcyc);
    bit done = 1'b0;
    tcyc = -1;
    if (who_b) begin b_valid[k] = 1'b1; b_addr[k] = ad; b_din[k] = d; b_wr[k] = wr; end
    else       begin a_valid[k] = 1'b1; a_addr[k] = ad; a_din[k] = d; a_wr[k] = wr; end
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = who_b ? b_ready[k] : a_ready[k];
      if (done) tcyc = cyc;
      tick();
    end
    a_valid[k] = 1'b0; b_valid[k] = 1'b0;
    chk("send_accept", int'(done), 1);
  endtask

  initial begin
    int s_cs, s_wrn, s_busy, s_arv, s_brv, t, na, nb;
    int own_q[$], cyc_q[$];
    for (int k = 0; k < 3; k++) begin
      a_addr[k] = 4'd0; b_addr[k] = 4'd0; a_din[k] = 8'd0; b_din[k] = 8'd0;
      cs_cnt[k] = 0; wrn_cnt[k] = 0; busy_cnt[k] = 0; arv_cnt[k] = 0; brv_cnt[k] = 0;
      brv_cyc[k] = 0; brv_dat[k] = 0; cs_addr[k] = 0; cs_din[k] = 0;
    end
    tick(); tick();
    @(negedge clk);
    chk("rst_cs_n", int'(psg_cs_n), 7);
    chk("rst_busy", int'(busy), 0);
    chk("rst_addr", int'(psg_addr[0]), 0);
    chk("rst_ready", int'({a_ready, b_ready}), 0);
    tick();

    // 1: single write, addr 7 data 0x38
    do_reset();
    s_cs = cs_cnt[0]; s_wrn = wrn_cnt[0]; s_busy = busy_cnt[0]; s_arv = arv_cnt[0];
    send(0, 1'b0, 4'h7, 8'h38, 1'b1, t);
    repeat (6) tick();
    chk("s1_cs_cycles", cs_cnt[0] - s_cs, 1);
    chk("s1_wr_cycles", wrn_cnt[0] - s_wrn, 1);
    chk("s1_cs_addr", cs_addr[0], 7);
    chk("s1_cs_din", cs_din[0], 'h38);
    chk("s1_no_rvalid", arv_cnt[0] - s_arv, 0);
    chk("s1_busy_cycles", busy_cnt[0] - s_busy, 3);

    // 2: round-robin tie, four grants
    do_reset();
    a_valid[0] = 1'b1; a_wr[0] = 1'b1; a_addr[0] = 4'h1; a_din[0] = 8'h11;
    b_valid[0] = 1'b1; b_wr[0] = 1'b1; b_addr[0] = 4'h2; b_din[0] = 8'h22;
    for (int i = 0; i < 40 && own_q.size() < 4; i++) begin
      @(negedge clk);
      if (a_ready[0]) begin own_q.push_back(0); cyc_q.push_back(cyc); end
      if (b_ready[0]) begin own_q.push_back(1); cyc_q.push_back(cyc); end
      tick();
    end
    a_valid[0] = 1'b0; b_valid[0] = 1'b0;
    chk("s2_grants", own_q.size(), 4);
    for (int i = 0; i < own_q.size(); i++) chk($sformatf("s2_owner%0d", i), own_q[i], i % 2);
    for (int i = 1; i < cyc_q.size(); i++) chk($sformatf("s2_spacing%0d", i), cyc_q[i] - cyc_q[i-1], 4);
    repeat (6) tick();

    // 3: B reads register 2 (PSG holds 0x5A)
    do_reset();
    s_arv = arv_cnt[0]; s_brv = brv_cnt[0];
    send(0, 1'b1, 4'h2, 8'h00, 1'b0, t);
    repeat (6) tick();
    chk("s3_b_rvalid_count", brv_cnt[0] - s_brv, 1);
    chk("s3_b_rvalid_cycle", brv_cyc[0], t + 3);
    chk("s3_b_rdata_pulse", brv_dat[0], 'h5A);
    chk("s3_b_rdata_hold", int'(b_rdata[0]), 'h5A);
    chk("s3_no_a_rvalid", arv_cnt[0] - s_arv, 0);

    // 4: fixed priority, both valid for 20 cycles
    do_reset();
    na = 0; nb = 0;
    a_valid[1] = 1'b1; a_wr[1] = 1'b1; a_addr[1] = 4'h3; a_din[1] = 8'hA1;
    b_valid[1] = 1'b1; b_wr[1] = 1'b1; b_addr[1] = 4'h4; b_din[1] = 8'hB1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_ready[1]) na++;
      if (b_ready[1]) nb++;
      tick();
    end
    a_valid[1] = 1'b0; b_valid[1] = 1'b0;
    chk("s4_a_grants", na, 5);
    chk("s4_b_ready_seen", nb, 0);
    repeat (6) tick();

    // 5: reset lands in the chip-select cycle of an A read
    do_reset();
    s_cs = cs_cnt[0]; s_arv = arv_cnt[0];
    send(0, 1'b0, 4'h3, 8'h00, 1'b0, t);
    rst = 1'b1;
    a_valid[0] = 1'b1; a_wr[0] = 1'b1; b_valid[0] = 1'b1; b_wr[0] = 1'b1;
    tick();
    @(negedge clk);
    chk("s5_cs_n_after_rst", int'(psg_cs_n[0]), 1);
    chk("s5_busy_after_rst", int'(busy[0]), 0);
    chk("s5_ready_in_rst", int'({a_ready[0], b_ready[0]}), 0);
    chk("s5_cs_cycles", cs_cnt[0] - s_cs, 1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("s5_tie_a_ready", int'(a_ready[0]), 1);
    chk("s5_tie_b_ready", int'(b_ready[0]), 0);
    tick();
    a_valid[0] = 1'b0; b_valid[0] = 1'b0;
    repeat (6) tick();
    chk("s5_no_a_rvalid", arv_cnt[0] - s_arv, 0);

    // 6: GAP=0, stream envelope-shape writes for 15 cycles
    do_reset();
    own_q.delete(); cyc_q.delete();
    s_cs = cs_cnt[2]; s_wrn = wrn_cnt[2];
    a_valid[2] = 1'b1; a_wr[2] = 1'b1; a_addr[2] = ENV_SHAPE; a_din[2] = 8'h0E;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (a_ready[2]) cyc_q.push_back(cyc);
      tick();
    end
    a_valid[2] = 1'b0;
    repeat (5) tick();
    chk("s6_writes", cyc_q.size(), 5);
    chk("s6_cs_cycles", cs_cnt[2] - s_cs, 5);
    chk("s6_wr_cycles", wrn_cnt[2] - s_wrn, 5);
    chk("s6_env_restarts", env_cnt[2], 5);
    chk("s6_env_eq_writes", env_cnt[2], cyc_q.size());
    for (int i = 1; i < cyc_q.size(); i++) chk($sformatf("s6_spacing%0d", i), cyc_q[i] - cyc_q[i-1], 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
